imem_load_ctrl: RTL and testbench
=================================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the instruction BRAM word-address width (1024 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port ld_start  in  1  a one-cycle pulse that begins a program load.
REQ-006 SHALL have port ld_len  in  ADDR_WIDTH+1  the number of words to load, sampled on ld_start.
REQ-007 SHALL have ports ld_valid  in  1 and ld_data  in  DATA_WIDTH, the program word stream.
REQ-008 SHALL have port ld_ready  out  1  the stream accept signal.
REQ-009 SHALL have ports f_req  in  1 and f_addr  in  ADDR_WIDTH, the core fetch request and word address.
REQ-010 SHALL have ports f_valid  out  1 and f_data  out  DATA_WIDTH, the fetch response.
REQ-011 SHALL have BRAM write-side ports bram_w_addr  out  ADDR_WIDTH, bram_w_dat  out  DATA_WIDTH and bram_w_enb  out  1.
REQ-012 SHALL have BRAM read-side ports bram_r_addr  out  ADDR_WIDTH, bram_r_enb  out  1 and bram_r_dat  in  DATA_WIDTH (1-cycle synchronous read).
REQ-013 SHALL have status ports core_hold  out  1, busy  out  1 and err  out  1.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, VERIFY, RUN and ERROR.
REQ-015 SHALL define the outputs per state: core_hold=1 in all states except RUN; busy=1 in LOAD and VERIFY; err=1 only in ERROR.
REQ-016 SHALL, on ld_start with 1<=ld_len<=2^ADDR_WIDTH in IDLE, RUN or ERROR, latch ld_len, clear the word counter and checksum, and enter LOAD on the next cycle; core_hold SHALL be 1 from that cycle onward.
REQ-017 SHALL, on ld_start with ld_len==0 or ld_len>2^ADDR_WIDTH, enter ERROR.
REQ-018 SHALL ignore ld_start while in LOAD or VERIFY.
REQ-019 SHALL drive ld_ready=1 only in LOAD.
REQ-020 SHALL, in LOAD, drive bram_w_enb=ld_valid&ld_ready combinationally in the same cycle as the handshake, with bram_w_addr=counter and bram_w_dat=ld_data.
REQ-021 SHALL hold bram_w_enb=0 in every state other than LOAD.
REQ-022 SHALL, on each accepted word in LOAD, increment the counter and update the checksum as csum = rotl1(csum) XOR word, with a 32-bit width and rotate-left by 1.
REQ-023 SHALL, on acceptance of word ld_len-1, enter VERIFY on the next cycle; ld_ready SHALL be 0 from that cycle.
REQ-024 SHALL, in VERIFY, issue reads at addresses 0..ld_len-1 on consecutive cycles with bram_r_enb=1.
REQ-025 SHALL, in VERIFY, fold the returned data (one cycle after each read) into a second checksum using the same rule as REQ-022.
REQ-026 SHALL, one cycle after the last read, enter RUN if the two checksums are equal and ERROR otherwise; VERIFY SHALL therefore last ld_len+1 cycles.
REQ-027 SHALL, in RUN, drive bram_r_enb=f_req and bram_r_addr=f_addr combinationally.
REQ-028 SHALL, in RUN, register f_valid=f_req, and SHALL drive f_data=bram_r_dat in the cycle f_valid=1, giving a 1-cycle fetch latency with back-to-back requests allowed.
REQ-029 SHALL, outside RUN, drop f_req: no fetch read is issued and f_valid=0 on the following cycle.
REQ-030 SHALL, on ld_start in RUN in the same cycle as f_req, give ld_start priority: the fetch read is still issued, but f_valid=0 on the next cycle.
REQ-031 SHALL make ERROR sticky; it exits only via rst or a valid ld_start.
REQ-032 SHALL wrap the word counter at no point, since ld_len is bounded to 2^ADDR_WIDTH by REQ-016 and REQ-017.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, enter IDLE and clear the counter and both checksums.
REQ-034 SHALL drive these reset values: core_hold=1, busy=0, err=0, ld_ready=0, f_valid=0, bram_w_enb=0, bram_r_enb=0, with all address and data outputs at 0.
REQ-035 SHALL abort a LOAD or VERIFY in progress when rst is asserted; BRAM contents are left as written.

Verification
REQ-036 SHALL verify basic load: ld_start with ld_len=4, then words 00500093, 00300113, 002081b3, 00000013 with ld_valid held high -> 4 writes at addr 0..3, VERIFY for 5 cycles, then RUN with core_hold=0.
REQ-037 SHALL verify fetch: in RUN, f_req=1 with f_addr=2 -> f_valid=1 and f_data=002081b3 on the next cycle; back-to-back reads of addresses 0..3 return all 4 words on consecutive cycles.
REQ-038 SHALL verify stream stalls: ld_valid toggled 1/0 during a 4-word load -> exactly 4 writes with no duplicate or skipped addresses.
REQ-039 SHALL verify checksum failure: a BRAM model corrupting address 1 on read-back -> ERROR with err=1 and core_hold=1; a later valid ld_start -> LOAD.
REQ-040 SHALL verify length errors: ld_start with ld_len=0, and separately with ld_len=1025 -> ERROR with no BRAM writes.
REQ-041 SHALL verify reset mid-operation: rst asserted after 2 of 4 words -> IDLE with ld_ready=0 and core_hold=1; f_req afterwards yields f_valid=0.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller.
// Streams a program into an instruction BRAM, reads it back to confirm a
// rotate-xor checksum, then serves single-cycle core fetches from the BRAM.
module imem_load_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // program stream
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH:0]   ld_len,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  // core fetch
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_valid,
  output logic [DATA_WIDTH-1:0] f_data,
  // BRAM write side
  output logic [ADDR_WIDTH-1:0] bram_w_addr,
  output logic [DATA_WIDTH-1:0] bram_w_dat,
  output logic                  bram_w_enb,
  // BRAM read side (1-cycle synchronous read)
  output logic [ADDR_WIDTH-1:0] bram_r_addr,
  output logic                  bram_r_enb,
  input  logic [DATA_WIDTH-1:0] bram_r_dat,
  // status
  output logic                  core_hold,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    VERIFY = 3'd2,
    RUN    = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         len;
  logic [CW-1:0]         cnt;          // write index in LOAD, read index in VERIFY
  logic [DATA_WIDTH-1:0] csum_ld;      // checksum of the streamed words
  logic [DATA_WIDTH-1:0] csum_rd;      // checksum of the read-back words
  logic [DATA_WIDTH-1:0] csum_rd_nxt;  // csum_rd with any returning read folded in
  logic                  rd_pend;      // a VERIFY read was issued last cycle
  logic                  rd_issue;
  logic                  start_ok;
  logic                  can_start;

  // Checksum step: rotate left by one, then xor in the new word.
  function automatic logic [DATA_WIDTH-1:0] csum_fold(
    input logic [DATA_WIDTH-1:0] c,
    input logic [DATA_WIDTH-1:0] w
  );
    return {c[DATA_WIDTH-2:0], c[DATA_WIDTH-1]} ^ w;
  endfunction

  assign start_ok  = ld_start && (ld_len != '0) && (ld_len <= MAX_LEN);
  assign can_start = (state == IDLE) || (state == RUN) || (state == ERROR);
  assign rd_issue  = (state == VERIFY) && (cnt != len);

  // BRAM port muxing and stream handshake; write strobe is same-cycle with the handshake
  always_comb begin
    ld_ready    = (state == LOAD);
    bram_w_enb  = ld_ready & ld_valid;
    bram_w_addr = ld_ready ? cnt[ADDR_WIDTH-1:0] : '0;
    bram_w_dat  = ld_ready ? ld_data : '0;
    bram_r_enb  = 1'b0;
    bram_r_addr = '0;
    if (rd_issue) begin
      bram_r_enb  = 1'b1;
      bram_r_addr = cnt[ADDR_WIDTH-1:0];
    end else if (state == RUN) begin
      bram_r_enb  = f_req;
      bram_r_addr = f_addr;
    end
    f_data = f_valid ? bram_r_dat : '0;
  end

  // Next-state decode; the last VERIFY cycle compares after folding the final read
  always_comb begin
    state_nxt   = state;
    csum_rd_nxt = rd_pend ? csum_fold(csum_rd, bram_r_dat) : csum_rd;
    case (state)
      IDLE, RUN, ERROR: begin
        if (ld_start) state_nxt = start_ok ? LOAD : ERROR;
      end
      LOAD: begin
        if (ld_valid && (cnt == len - 1'b1)) state_nxt = VERIFY;
      end
      VERIFY: begin
        if (!rd_issue) state_nxt = (csum_rd_nxt == csum_ld) ? RUN : ERROR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Controller state, counters, checksums and registered status/fetch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      csum_ld   <= '0;
      csum_rd   <= '0;
      rd_pend   <= 1'b0;
      core_hold <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
      f_valid   <= 1'b0;
    end else begin
      rd_pend <= 1'b0;
      case (state)
        IDLE, RUN, ERROR: begin
          if (start_ok) begin
            len     <= ld_len;
            cnt     <= '0;
            csum_ld <= '0;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            cnt     <= cnt + 1'b1;
            csum_ld <= csum_fold(csum_ld, ld_data);
            if (state_nxt == VERIFY) begin
              cnt     <= '0;
              csum_rd <= '0;
            end
          end
        end
        VERIFY: begin
          csum_rd <= csum_rd_nxt;
          rd_pend <= rd_issue;
          if (rd_issue) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
      // a load request in RUN pre-empts the response of a same-cycle fetch
      f_valid   <= (state == RUN) && f_req && !ld_start;
      state     <= state_nxt;
      core_hold <= (state_nxt != RUN);
      busy      <= (state_nxt == LOAD) || (state_nxt == VERIFY);
      err       <= (state_nxt == ERROR);
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl with a BRAM model and a
// list-based reference model of the program image and checksums.
module tb_imem_load_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_start = 1'b0;
  logic [AW:0]   ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_valid;
  logic [DW-1:0] f_data;
  logic [AW-1:0] bram_w_addr;
  logic [DW-1:0] bram_w_dat;
  logic          bram_w_enb;
  logic [AW-1:0] bram_r_addr;
  logic          bram_r_enb;
  logic [DW-1:0] bram_r_dat = '0;
  logic          core_hold;
  logic          busy;
  logic          err;

  imem_load_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready),
    .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_data(f_data),
    .bram_w_addr(bram_w_addr), .bram_w_dat(bram_w_dat), .bram_w_enb(bram_w_enb),
    .bram_r_addr(bram_r_addr), .bram_r_enb(bram_r_enb), .bram_r_dat(bram_r_dat),
    .core_hold(core_hold), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // BRAM model, optional read-back corruption of address 1, plus access logs
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            corrupt = 1'b0;
  int            wlog_a[$];
  logic [DW-1:0] wlog_d[$];
  int            rlog[$];

  always @(posedge clk) begin
    if (bram_w_enb) begin
      mem[bram_w_addr] <= bram_w_dat;
      wlog_a.push_back(int'(bram_w_addr));
      wlog_d.push_back(bram_w_dat);
    end
    if (bram_r_enb) begin
      bram_r_dat <= mem[bram_r_addr] ^ ((corrupt && bram_r_addr == 1) ? 32'h0000_0100 : 32'h0);
      if (busy) rlog.push_back(int'(bram_r_addr));
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] words[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] csum_of(input logic [DW-1:0] q[$]);
    logic [DW-1:0] c = '0;
    foreach (q[i]) c = {c[DW-2:0], c[DW-1]} ^ q[i];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run a complete load of `words`; checks writes, read-back, VERIFY length and outcome
  task automatic do_load(input bit stall, input bit poke);
    int n = words.size();
    int idx = 0;
    int cyc = 0;
    int vc = 0;
    int nbad = 0;
    logic [DW-1:0] rb[$];
    wlog_a.delete(); wlog_d.delete(); rlog.delete();
    ld_len = (AW+1)'(n);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("load_hold", core_hold, 1);
    chk("load_ready", ld_ready, 1);
    while (idx < n && cyc < 20000) begin
      ld_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = ld_valid ? words[idx] : $urandom;
      if (poke && idx == 1) begin
        ld_start = 1'b1;
        ld_len   = '0;
      end
      tick();
      ld_start = 1'b0;
      if (ld_valid) idx++;
      cyc++;
    end
    ld_valid = 1'b0;
    chk("load_timeout", (cyc < 20000), 1);
    chk("verify_ready", ld_ready, 0);
    chk("wr_count", wlog_a.size(), n);
    for (int i = 0; i < n && i < wlog_a.size(); i++)
      if (wlog_a[i] != i || wlog_d[i] !== words[i]) nbad++;
    chk("wr_seq", nbad, 0);
    for (int i = 0; i < n; i++) begin
      ref_mem[i] = words[i];
      rb.push_back((corrupt && i == 1) ? (words[i] ^ 32'h0000_0100) : words[i]);
    end
    while (busy && !ld_ready && vc < 3000) begin
      vc++;
      tick();
    end
    chk("verify_cycles", vc, n + 1);
    chk("rd_count", rlog.size(), n);
    nbad = 0;
    for (int i = 0; i < rlog.size(); i++) if (rlog[i] != i) nbad++;
    chk("rd_seq", nbad, 0);
    if (csum_of(words) == csum_of(rb)) begin
      chk("run_hold", core_hold, 0);
      chk("run_err", err, 0);
    end else begin
      chk("err_flag", err, 1);
      chk("err_hold", core_hold, 1);
    end
    chk("done_busy", busy, 0);
  endtask

  // Back-to-back fetches; sequential 0..n-1 or random addresses below n
  task automatic fetch_burst(input int n, input bit rnd);
    int a;
    for (int i = 0; i < n; i++) begin
      a = rnd ? int'($urandom_range(0, n - 1)) : i;
      f_req  = 1'b1;
      f_addr = AW'(a);
      #1;
      chk("fetch_renb", bram_r_enb, 1);
      tick();
      chk("fetch_valid", f_valid, 1);
      chk("fetch_data", f_data, ref_mem[a]);
    end
    f_req = 1'b0;
    tick();
    chk("fetch_idle", f_valid, 0);
  endtask

  // Illegal-length request must land in ERROR without writing the BRAM
  task automatic len_err(input int n);
    wlog_a.delete();
    ld_len   = (AW+1)'(n);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = $urandom;
    tick();
    ld_start = 1'b0;
    chk("lenerr_err", err, 1);
    chk("lenerr_hold", core_hold, 1);
    chk("lenerr_ready", ld_ready, 0);
    repeat (3) tick();
    ld_valid = 1'b0;
    chk("lenerr_nowr", wlog_a.size(), 0);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    // reset values
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_hold", core_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_fvalid", f_valid, 0);
    chk("rst_wenb", bram_w_enb, 0);
    chk("rst_renb", bram_r_enb, 0);
    chk("rst_waddr", bram_w_addr, 0);

    // directed program load and fetches
    words = '{32'h00500093, 32'h00300113, 32'h002081b3, 32'h00000013};
    do_load(1'b0, 1'b0);
    f_req = 1'b1; f_addr = 2;
    tick();
    f_req = 1'b0;
    chk("fetch2_valid", f_valid, 1);
    chk("fetch2_data", f_data, 32'h002081b3);
    fetch_burst(4, 1'b0);

    // randomized loads with stream stalls; first one also pokes ld_start mid-load
    for (int t = 0; t < 4; t++) begin
      rand_words(int'($urandom_range(3, 9)));
      do_load(1'b1, (t == 0));
      fetch_burst(words.size(), 1'b1);
    end

    // load request colliding with a fetch, then reset after two words
    wlog_a.delete();
    f_req = 1'b1; f_addr = 0; ld_len = 4; ld_start = 1'b1;
    #1;
    chk("prio_renb", bram_r_enb, 1);
    tick();
    ld_start = 1'b0; f_req = 1'b0;
    chk("prio_fvalid", f_valid, 0);
    chk("prio_ready", ld_ready, 1);
    ld_valid = 1'b1; ld_data = $urandom;
    tick();
    ld_data = $urandom;
    tick();
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_writes", wlog_a.size(), 2);
    chk("abort_ready", ld_ready, 0);
    chk("abort_hold", core_hold, 1);
    chk("abort_busy", busy, 0);
    f_req = 1'b1; f_addr = 0;
    #1;
    chk("idle_renb", bram_r_enb, 0);
    tick();
    f_req = 1'b0;
    chk("idle_fvalid", f_valid, 0);

    // read-back corruption leads to sticky ERROR, then recovery via a new load
    corrupt = 1'b1;
    rand_words(4);
    do_load(1'b0, 1'b0);
    corrupt = 1'b0;
    f_req = 1'b1; f_addr = 0;
    repeat (2) tick();
    f_req = 1'b0;
    chk("err_fvalid", f_valid, 0);
    chk("err_sticky", err, 1);
    rand_words(5);
    do_load(1'b1, 1'b0);

    // length errors, each from RUN
    len_err(0);
    rand_words(2);
    do_load(1'b0, 1'b0);
    len_err(1025);

    // full-size image exercises the top of the address range
    rand_words(1 << AW);
    do_load(1'b0, 1'b0);
    f_req = 1'b1; f_addr = AW'((1 << AW) - 1);
    tick();
    f_req = 1'b0;
    chk("max_fetch", f_data, ref_mem[(1 << AW) - 1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
